uart_transmit_fifo: RTL

UART_TRANSMIT_FIFO -- requirements
Module: uart_transmit_fifo

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_transmit_fifo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared FSM state encoding and parity-mode constants for the UART transmitter.
// No logic: types and constants only.
// No flow control of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word visible on pop_data_out.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full (even with a pop that cycle); pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_in,
  input  logic [WIDTH-1:0]         push_data_in,
  input  logic                     pop_in,
  output logic [WIDTH-1:0]         pop_data_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_in && (count_q != FULL_CNT);
    do_pop   = pop_in && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign pop_data_out = mem_q[rd_ptr_q];
  assign count_out    = count_q;

endmodule

// File: rtl/uart_transmit_fifo.sv
// Buffered UART transmitter (FIFO + serialiser); parity bit only with UART_TX_PARITY_EN defined.
// Latency: first start-bit cycle on tx_wire_out two edges after the accepting edge when idle.
// Backpressure: ready_out low while FIFO full; frames run back-to-back while words are queued.
module uart_transmit_fifo
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_BITS        = 8,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4,
  parameter int PARITY_MODE      = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          valid_in,
  input  logic [DATA_BITS-1:0]          data_in,
  output logic                          ready_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          tx_wire_out
);

  localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CW   = $clog2(BAUD_BIT_PERIOD);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_BIT_PERIOD - 1);
  localparam logic [IW-1:0]   DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]   STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam bit   HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic ODD_FLIP   = (PARITY_MODE == PARITY_ODD);
  logic parity_q, parity_d;
`else
  if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity_mode
    $error("PARITY_MODE must be 0, 1 or 2");
  end
`endif

  tx_state_e          state_q, state_d;
  logic [CW-1:0]      baud_cnt_q, baud_cnt_d;
  logic [IW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic               tx_q, tx_d;

  logic [DATA_BITS-1:0] fifo_dat;
  logic [CNTW-1:0]      fifo_cnt;
  logic                 fifo_push, fifo_pop;
  logic                 fifo_empty, bit_end, load;

  assign ready_out = (fifo_cnt < FULL_CNT);
  assign fifo_push = valid_in && ready_out;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_sync_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (fifo_push),
    .push_data_in (data_in),
    .pop_in       (fifo_pop),
    .pop_data_out (fifo_dat),
    .count_out    (fifo_cnt)
  );

  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    bit_end    = (baud_cnt_q == BAUD_LAST);
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    load       = 1'b0;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        load       = !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = HAS_PARITY ? PARITY : STOP;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            state_d = IDLE;
            load    = !fifo_empty;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Popping straight out of the last stop bit keeps frames gap-free.
    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = START;
      shift_d    = fifo_dat;
      bit_idx_d  = '0;
      baud_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d   = (^fifo_dat) ^ ODD_FLIP;
`endif
    end

    // The line is re-registered from the current state, so it trails the FSM by one cycle.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign busy_out       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count_out = fifo_cnt;
  assign tx_wire_out    = tx_q;

endmodule
